// File: rtl/hit_event_manager.sv
`timescale 1ns/1ps
// Folds per-pixel overlaps into one event pulse per type per frame, and owns
// lives, post-hit invulnerability blinking and the IDLE/PLAY/HIT/GAME_OVER flow.
module hit_event_manager #(
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       game_start,
  input  logic       collision,
  input  logic       collisionBanana,
  input  logic       drawing_request_spaceship,
  input  logic       drawing_request_banana,
  input  logic       drawing_request_shield,
  output logic       projectile_kill,
  output logic       banana_kill,
  output logic       shield_hit,
  output logic       ship_hit,
  output logic [1:0] lives,
  output logic [7:0] shield_hit_count,
  output logic       ship_visible,
  output logic       freeze,
  output logic       game_over
);

  localparam int CNT_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
  localparam int BLK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_PERIOD - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HIT, S_OVER} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state, state_nx;
  logic [1:0]       lives_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [BLK_W-1:0] blk, blk_nx;
  logic             vis_nx;
  logic [7:0]       hits_nx;
  logic             flag_clr, active, vld_p0;
  logic             t_proj, t_banana, t_ship, t_shield;
  logic             f_proj, f_banana, f_ship, f_shield;
  logic             pk_nx, bk_nx, sh_nx, shp_nx;
  logic             pk_p1, bk_p1, sh_p1, shp_p1;

  assign t_proj   = collision;
  assign t_banana = collisionBanana;
  assign t_ship   = collisionBanana & drawing_request_spaceship & drawing_request_banana;
  assign t_shield = (collision | collisionBanana) & drawing_request_shield;

  // Stage p0: frame flags accumulate; startOfFrame samples the old frame and restarts.
  always_ff @(posedge clk) begin
    if (reset || flag_clr) begin
      f_proj   <= 1'b0;
      f_banana <= 1'b0;
      f_ship   <= 1'b0;
      f_shield <= 1'b0;
    end else if (startOfFrame) begin
      f_proj   <= t_proj;
      f_banana <= t_banana;
      f_ship   <= t_ship;
      f_shield <= t_shield;
    end else begin
      f_proj   <= f_proj   | t_proj;
      f_banana <= f_banana | t_banana;
      f_ship   <= f_ship   | t_ship;
      f_shield <= f_shield | t_shield;
    end
  end

  always_comb begin
    state_nx = state;
    lives_nx = lives;
    cnt_nx   = cnt;
    blk_nx   = blk;
    vis_nx   = ship_visible;
    flag_clr = 1'b0;
    active   = (state == S_PLAY) || (state == S_HIT);
    vld_p0   = startOfFrame & active;
    pk_nx    = vld_p0 & f_proj;
    bk_nx    = vld_p0 & f_banana;
    sh_nx    = vld_p0 & f_shield;
    shp_nx   = 1'b0;
    hits_nx  = sh_nx ? sat_inc8(shield_hit_count) : shield_hit_count;
    case (state)
      S_PLAY: begin
        if (vld_p0 && f_ship && (lives != 2'd0)) begin
          shp_nx   = 1'b1;
          lives_nx = lives - 2'd1;
          if (lives == 2'd1) begin
            state_nx = S_OVER;
          end else begin
            state_nx = S_HIT;
            cnt_nx   = '0;
            blk_nx   = '0;
            vis_nx   = 1'b0;
          end
        end
      end
      S_HIT: begin
        // Ship overlaps are ignored here; the counter sits on its last value for one full frame.
        if (vld_p0) begin
          if (cnt == CNT_LAST) begin
            state_nx = S_PLAY;
            vis_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
            if (blk == BLK_LAST) begin
              blk_nx = '0;
              vis_nx = ~ship_visible;
            end else begin
              blk_nx = blk + 1'b1;
            end
          end
        end
      end
      default: begin
        if (game_start) begin
          state_nx = S_PLAY;
          lives_nx = LIVES_INIT;
          hits_nx  = 8'd0;
          vis_nx   = 1'b1;
          flag_clr = 1'b1;
        end
      end
    endcase
  end

  // Stage p1: registered pulses and game state, one clock after the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      lives            <= 2'd0;
      cnt              <= '0;
      blk              <= '0;
      ship_visible     <= 1'b1;
      shield_hit_count <= 8'd0;
      pk_p1            <= 1'b0;
      bk_p1            <= 1'b0;
      sh_p1            <= 1'b0;
      shp_p1           <= 1'b0;
    end else begin
      state            <= state_nx;
      lives            <= lives_nx;
      cnt              <= cnt_nx;
      blk              <= blk_nx;
      ship_visible     <= vis_nx;
      shield_hit_count <= hits_nx;
      pk_p1            <= pk_nx;
      bk_p1            <= bk_nx;
      sh_p1            <= sh_nx;
      shp_p1           <= shp_nx;
    end
  end

  assign projectile_kill = pk_p1;
  assign banana_kill     = bk_p1;
  assign shield_hit      = sh_p1;
  assign ship_hit        = shp_p1;
  assign freeze          = (state == S_IDLE) || (state == S_OVER);
  assign game_over       = (state == S_OVER);

endmodule

// File: tb/tb_hit_event_manager.sv
`timescale 1ns/1ps
// Randomized bench for hit_event_manager with a frame-level game model.
module tb_hit_event_manager;
  localparam int START_LIVES   = 3;
  localparam int INVULN_FRAMES = 60;
  localparam int BLINK_PERIOD  = 4;
  localparam int FL            = 24;

  logic clk = 1'b0, reset = 1'b0, startOfFrame = 1'b0, game_start = 1'b0;
  logic collision = 1'b0, collisionBanana = 1'b0;
  logic drawing_request_spaceship = 1'b0, drawing_request_banana = 1'b0, drawing_request_shield = 1'b0;
  logic projectile_kill, banana_kill, shield_hit, ship_hit, ship_visible, freeze, game_over;
  logic [1:0] lives;
  logic [7:0] shield_hit_count;

  hit_event_manager #(.START_LIVES(START_LIVES), .INVULN_FRAMES(INVULN_FRAMES), .BLINK_PERIOD(BLINK_PERIOD)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .game_start(game_start),
    .collision(collision), .collisionBanana(collisionBanana),
    .drawing_request_spaceship(drawing_request_spaceship),
    .drawing_request_banana(drawing_request_banana),
    .drawing_request_shield(drawing_request_shield),
    .projectile_kill(projectile_kill), .banana_kill(banana_kill), .shield_hit(shield_hit),
    .ship_hit(ship_hit), .lives(lives), .shield_hit_count(shield_hit_count),
    .ship_visible(ship_visible), .freeze(freeze), .game_over(game_over));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, sof_cyc = 0, pk_lat = -1;
  int n_pk = 0, n_bk = 0, n_sh = 0, n_shp = 0, pulse_err = 0, st_err = 0;

  // Game model: 0 idle, 1 play, 2 hit, 3 game over
  int m_state = 0, m_lives = 0, m_count = 0, m_hitfr = 0;
  bit m_vis = 1'b1;
  bit fp = 0, fb = 0, fs = 0, fsh = 0;
  bit e_pk = 0, e_bk = 0, e_sh = 0, e_shp = 0;

  task automatic model_step();
    bit clr, act, t_p, t_b, t_s, t_sh;
    clr = 1'b0;
    if (reset) begin
      m_state = 0; m_lives = 0; m_count = 0; m_vis = 1'b1; m_hitfr = 0;
      fp = 0; fb = 0; fs = 0; fsh = 0;
      e_pk = 0; e_bk = 0; e_sh = 0; e_shp = 0;
      return;
    end
    t_p  = collision;
    t_b  = collisionBanana;
    t_s  = collisionBanana & drawing_request_spaceship & drawing_request_banana;
    t_sh = (collision | collisionBanana) & drawing_request_shield;
    act  = (m_state == 1) || (m_state == 2);
    if (startOfFrame) sof_cyc = cyc;
    e_pk  = startOfFrame && act && fp;
    e_bk  = startOfFrame && act && fb;
    e_sh  = startOfFrame && act && fsh;
    e_shp = 1'b0;
    if (e_sh && m_count < 255) m_count++;
    case (m_state)
      1: if (startOfFrame && fs) begin
        e_shp = 1'b1;
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) m_state = 3;
        else begin m_state = 2; m_hitfr = 0; m_vis = 1'b0; end
      end
      2: if (startOfFrame) begin
        if (m_hitfr == INVULN_FRAMES - 1) begin m_state = 1; m_vis = 1'b1; end
        else begin m_hitfr++; m_vis = ((m_hitfr / BLINK_PERIOD) % 2) == 1; end
      end
      default: if (game_start) begin
        m_state = 1; m_lives = START_LIVES; m_count = 0; m_vis = 1'b1; clr = 1'b1;
      end
    endcase
    if (clr) begin fp = 0; fb = 0; fs = 0; fsh = 0; end
    else if (startOfFrame) begin fp = t_p; fb = t_b; fs = t_s; fsh = t_sh; end
    else begin fp |= t_p; fb |= t_b; fs |= t_s; fsh |= t_sh; end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if ({projectile_kill, banana_kill, shield_hit, ship_hit} !== {e_pk, e_bk, e_sh, e_shp}) pulse_err++;
    if (lives !== 2'(m_lives) || shield_hit_count !== 8'(m_count) || ship_visible !== m_vis ||
        freeze !== ((m_state == 0) || (m_state == 3)) || game_over !== (m_state == 3)) st_err++;
    if (projectile_kill === 1'b1) begin n_pk++; pk_lat = cyc - sof_cyc; end
    if (banana_kill === 1'b1) n_bk++;
    if (shield_hit === 1'b1) n_sh++;
    if (ship_hit === 1'b1) n_shp++;
  endtask

  task automatic drive(input bit sof, input bit c, input bit cb, input bit ds, input bit db, input bit dsh);
    startOfFrame = sof; collision = c; collisionBanana = cb;
    drawing_request_spaceship = ds; drawing_request_banana = db; drawing_request_shield = dsh;
    tick();
  endtask

  // en: bit0 projectile, bit1 banana, bit2 banana-on-ship, bit3 shield; one forced cycle guarantees each enabled event
  task automatic run_frame(input int len, input bit [3:0] en);
    int f;
    bit c, cb, ds, db, dsh;
    f = $urandom_range(1, len - 1);
    for (int i = 0; i < len; i++) begin
      if (i == f) begin
        c = en[0] | (en[3] & ~(en[1] | en[2]));
        cb = en[1] | en[2]; ds = en[2]; db = en[2]; dsh = en[3];
      end else begin
        c   = en[0] && ($urandom_range(0, 5) == 0);
        cb  = (en[1] | en[2]) && ($urandom_range(0, 5) == 0);
        ds  = en[2] && ($urandom_range(0, 1) == 1);
        db  = ($urandom_range(0, 1) == 1);
        dsh = en[3] && ($urandom_range(0, 1) == 1);
      end
      drive(i == 0, c, cb, ds, db, dsh);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1, 1, 1, 1, 1);
    drive(1, 1, 1, 1, 1, 1);
    reset = 1'b0;
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL reset_lives: got %0d expected 0", lives); end
    checks++; if (shield_hit_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", shield_hit_count); end
    checks++; if ({ship_visible, freeze, game_over} !== 3'b110) begin errors++; $display("FAIL reset_flags: got %b expected 110", {ship_visible, freeze, game_over}); end
    checks++; if ({projectile_kill, banana_kill, shield_hit, ship_hit} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {projectile_kill, banana_kill, shield_hit, ship_hit}); end
  endtask

  task automatic test_start();
    int b;
    b = n_pk + n_bk + n_sh + n_shp;
    game_start = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    game_start = 1'b0;
    run_frame(FL, 4'b0000);
    run_frame(FL, 4'b0000);
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL start_lives: got %0d expected 3", lives); end
    checks++; if ({freeze, game_over} !== 2'b00) begin errors++; $display("FAIL start_state: got %b expected 00", {freeze, game_over}); end
    checks++; if (n_pk + n_bk + n_sh + n_shp !== b) begin errors++; $display("FAIL start_no_pulses: got %0d expected %0d", n_pk + n_bk + n_sh + n_shp, b); end
  endtask

  task automatic test_projectile_kill();
    int b_pk, b_bk;
    b_pk = n_pk; b_bk = n_bk; pk_lat = -1;
    drive(1, 0, 0, 0, 0, 0);
    repeat (50) drive(0, 1, 0, 0, 0, 0);
    repeat (9) drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (FL) drive(0, 0, 0, 0, 0, 0);
    checks++; if (n_pk - b_pk !== 1) begin errors++; $display("FAIL proj_count: got %0d expected 1", n_pk - b_pk); end
    checks++; if (pk_lat !== 1) begin errors++; $display("FAIL proj_latency: got %0d expected 1", pk_lat); end
    checks++; if (n_bk - b_bk !== 0) begin errors++; $display("FAIL proj_no_banana: got %0d expected 0", n_bk - b_bk); end
  endtask

  task automatic test_ship_shield();
    drive(1, 0, 0, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 1);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    checks++; if ({projectile_kill, banana_kill, shield_hit, ship_hit} !== 4'b0111) begin errors++; $display("FAIL ship_pulses: got %b expected 0111", {projectile_kill, banana_kill, shield_hit, ship_hit}); end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (lives !== 2'd2) begin errors++; $display("FAIL ship_lives: got %0d expected 2", lives); end
    checks++; if (ship_visible !== 1'b0) begin errors++; $display("FAIL ship_hidden: got %b expected 0", ship_visible); end
    checks++; if (shield_hit_count !== 8'd1) begin errors++; $display("FAIL shield_count: got %0d expected 1", shield_hit_count); end
    checks++; if ({projectile_kill, banana_kill, shield_hit, ship_hit} !== 4'b0000) begin errors++; $display("FAIL ship_single_pulse: got %b expected 0000", {projectile_kill, banana_kill, shield_hit, ship_hit}); end
  endtask

  task automatic test_invulnerability();
    int b_shp;
    bit exp_vis;
    b_shp = n_shp;
    repeat (FL - 2) drive(0, 0, 1, 1, 1, 0);
    checks++; if (ship_visible !== 1'b0) begin errors++; $display("FAIL blink_frame0: got %b expected 0", ship_visible); end
    for (int j = 1; j < INVULN_FRAMES; j++) begin
      run_frame(FL, 4'b0100);
      exp_vis = ((j / BLINK_PERIOD) % 2) == 1;
      checks++; if (ship_visible !== exp_vis) begin errors++; $display("FAIL blink_frame%0d: got %b expected %b", j, ship_visible, exp_vis); end
    end
    run_frame(FL, 4'b0000);
    checks++; if ({ship_visible, freeze} !== 2'b10) begin errors++; $display("FAIL resume_play: got %b expected 10", {ship_visible, freeze}); end
    checks++; if (lives !== 2'd2) begin errors++; $display("FAIL invuln_lives: got %0d expected 2", lives); end
    checks++; if (n_shp - b_shp !== 0) begin errors++; $display("FAIL invuln_no_hit: got %0d expected 0", n_shp - b_shp); end
  endtask

  task automatic test_game_over();
    int b_shp, b_all;
    b_shp = n_shp;
    run_frame(FL, 4'b0100);
    run_frame(FL, 4'b0000);
    checks++; if (lives !== 2'd1) begin errors++; $display("FAIL second_hit_lives: got %0d expected 1", lives); end
    game_start = 1'b1;
    run_frame(FL, 4'b1011);
    game_start = 1'b0;
    checks++; if (lives !== 2'd1) begin errors++; $display("FAIL start_ignored: got %0d expected 1", lives); end
    repeat (INVULN_FRAMES) run_frame(FL, 4'b1011);
    run_frame(FL, 4'b0100);
    run_frame(FL, 4'b0000);
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL over_lives: got %0d expected 0", lives); end
    checks++; if ({game_over, freeze} !== 2'b11) begin errors++; $display("FAIL over_state: got %b expected 11", {game_over, freeze}); end
    checks++; if (n_shp - b_shp !== 2) begin errors++; $display("FAIL over_hits: got %0d expected 2", n_shp - b_shp); end
    b_all = n_pk + n_bk + n_sh + n_shp;
    repeat (3) run_frame(FL, 4'b1111);
    checks++; if (n_pk + n_bk + n_sh + n_shp !== b_all) begin errors++; $display("FAIL over_silent: got %0d expected %0d", n_pk + n_bk + n_sh + n_shp, b_all); end
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL over_hold: got %0d expected 0", lives); end
    game_start = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    game_start = 1'b0;
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL restart_lives: got %0d expected 3", lives); end
    checks++; if ({shield_hit_count, freeze, game_over} !== 10'd0) begin errors++; $display("FAIL restart_state: got %0d/%b%b expected 0/00", shield_hit_count, freeze, game_over); end
  endtask

  task automatic test_shield_saturation();
    int b_sh;
    b_sh = n_sh;
    repeat (260) run_frame(8, 4'b1000);
    run_frame(8, 4'b0000);
    checks++; if (n_sh - b_sh !== 260) begin errors++; $display("FAIL shield_pulses: got %0d expected 260", n_sh - b_sh); end
    checks++; if (shield_hit_count !== 8'd255) begin errors++; $display("FAIL shield_saturate: got %0d expected 255", shield_hit_count); end
  endtask

  task automatic test_sof_overlap_and_reset();
    int b_all;
    drive(1, 1, 0, 0, 0, 0);
    checks++; if (projectile_kill !== 1'b0) begin errors++; $display("FAIL sof_overlap_early: got %b expected 0", projectile_kill); end
    repeat (FL - 1) drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (projectile_kill !== 1'b1) begin errors++; $display("FAIL sof_overlap_next: got %b expected 1", projectile_kill); end
    run_frame(FL, 4'b0100);
    run_frame(FL, 4'b0001);
    checks++; if ({ship_visible, freeze, lives} !== 4'b0010) begin errors++; $display("FAIL pre_reset_hit: got %b expected 0010", {ship_visible, freeze, lives}); end
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    checks++; if ({projectile_kill, banana_kill, shield_hit, ship_hit} !== 4'b0000) begin errors++; $display("FAIL reset_drops_pulse: got %b expected 0000", {projectile_kill, banana_kill, shield_hit, ship_hit}); end
    checks++; if ({lives, freeze, ship_visible, shield_hit_count} !== {2'd0, 2'b11, 8'd0}) begin errors++; $display("FAIL reset_mid_hit: got %0d/%b%b/%0d expected 0/11/0", lives, freeze, ship_visible, shield_hit_count); end
    b_all = n_pk + n_bk + n_sh + n_shp;
    repeat (2) run_frame(FL, 4'b1111);
    checks++; if (n_pk + n_bk + n_sh + n_shp !== b_all) begin errors++; $display("FAIL idle_silent: got %0d expected %0d", n_pk + n_bk + n_sh + n_shp, b_all); end
  endtask

  task automatic test_model_agreement();
    checks++; if (pulse_err !== 0) begin errors++; $display("FAIL model_pulses: got %0d bad cycles expected 0", pulse_err); end
    checks++; if (st_err !== 0) begin errors++; $display("FAIL model_state: got %0d bad cycles expected 0", st_err); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_projectile_kill();
    test_ship_shield();
    test_invulnerability();
    test_game_over();
    test_shield_saturation();
    test_sof_overlap_and_reset();
    test_model_agreement();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
